// File: rtl/cosine_sim_core.sv
// cosine_sim_core
//   Sequential cosine-similarity engine: similarity = dot(A,B) / (|A|*|B|)
//   for two W-element signed Q16.16 vectors. One MAC pass accumulates the dot
//   product and both squared norms. Two bit-serial square roots run in parallel.
//   One multiply forms the denominator. A restoring divider then produces a
//   Q16.16 quotient. The result is held until the next completed operation.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous, active-high reset (aborts any operation)
//     start      request pulse, sampled only while idle
//     vec_a      W packed signed Q16.16 elements, element i at [32*i +: 32]
//     vec_b      W packed signed Q16.16 elements, element i at [32*i +: 32]
//     similarity signed Q16.16 result, updated only on completion or reset
//     valid      one-cycle completion pulse
//
//   Build option:
//     COSINE_SIM_CLAMP_EN  when defined, the result is clamped to -1.0 .. +1.0.
//                          Latency is the same in both builds.
module cosine_sim_core #(
    parameter int W    = 5,
    parameter int FRAC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [32*W-1:0] vec_a,
    input  logic [32*W-1:0] vec_b,
    output logic [31:0]     similarity,
    output logic            valid
);
    localparam int ACCW = 64 + $clog2(W) + 1;   // signed accumulator width
    localparam int SQ   = ACCW / 2;             // sqrt iterations = ceil((ACCW-1)/2)
    localparam int NW   = 2 * SQ;               // unsigned norm / denominator width
    localparam int RMW  = SQ + 1;               // sqrt partial remainder width
    localparam int RDW  = NW + 2;               // divider partial remainder width
    localparam int QW   = 32;                   // quotient bits / divide cycles
    localparam int CW   = $clog2(W + SQ + QW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_SQRT,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic          last;

    logic [32*W-1:0]        a_sh, b_sh;
    logic signed [ACCW-1:0] dot;
    logic [NW-1:0]          na, nb;
    logic [RMW-1:0]         rem_a, rem_b;
    logic [SQ-1:0]          root_a, root_b;
    logic [NW-1:0]          den;
    logic [RDW-1:0]         r;
    logic [QW-1:0]          lo;
    logic [QW-2:0]          q;
    logic                   neg, ovf;

    logic signed [63:0]  p_ab, p_aa, p_bb;
    logic [RMW+SQ-1:0]   sq_a_nx, sq_b_nx;
    logic [ACCW-1:0]     dmag;
    logic [RDW-1:0]      r_sh, r_nx;
    logic                qbit;
    logic [QW-1:0]       q_nx, mag, res;

    // One digit-by-digit square-root step: bring down the next two radicand
    // bits and try to append a 1 to the root.
    function automatic logic [RMW+SQ-1:0] sqrt_step(
        input logic [RMW-1:0] rem,
        input logic [SQ-1:0]  root,
        input logic [1:0]     pair
    );
        logic [RMW+1:0] rs, trial;
        rs    = {rem, pair};
        trial = {1'b0, root, 2'b01};
        if (rs >= trial)
            return {RMW'(rs - trial), root[SQ-2:0], 1'b1};
        else
            return {RMW'(rs), root[SQ-2:0], 1'b0};
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        last     = 1'b0;
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_MAC;
            S_MAC: begin
                last = (cnt == CW'(W - 1));
                if (last) state_nx = S_SQRT;
            end
            S_SQRT: begin
                last = (cnt == CW'(SQ - 1));
                if (last) state_nx = S_MUL;
            end
            S_MUL:  state_nx = S_DIV;
            S_DIV: begin
                last = (cnt == CW'(QW - 1));
                if (last) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- datapath combinational ----------------
    always_comb begin
        p_ab = $signed(a_sh[31:0]) * $signed(b_sh[31:0]);
        p_aa = $signed(a_sh[31:0]) * $signed(a_sh[31:0]);
        p_bb = $signed(b_sh[31:0]) * $signed(b_sh[31:0]);

        // Norm registers are shifted left during SQRT, so the next radicand
        // pair is always the top two bits.
        sq_a_nx = sqrt_step(rem_a, root_a, na[NW-1 -: 2]);
        sq_b_nx = sqrt_step(rem_b, root_b, nb[NW-1 -: 2]);

        dmag = dot[ACCW-1] ? -dot : dot;

        // Dividend is |dot| << FRAC. Its upper part seeds r and its low QW bits
        // are fed in one per cycle from lo.
        r_sh = {r[RDW-2:0], lo[QW-1]};
        qbit = (r_sh >= RDW'(den));
        r_nx = qbit ? (r_sh - RDW'(den)) : r_sh;
        q_nx = {q, qbit};

        mag = (ovf || q_nx[QW-1]) ? 32'h7FFF_FFFF : q_nx;
`ifdef COSINE_SIM_CLAMP_EN
        if (mag > 32'h0001_0000) mag = 32'h0001_0000;
`endif
        if (den == '0) mag = '0;
        res = neg ? -mag : mag;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            a_sh       <= '0;
            b_sh       <= '0;
            dot        <= '0;
            na         <= '0;
            nb         <= '0;
            rem_a      <= '0;
            rem_b      <= '0;
            root_a     <= '0;
            root_b     <= '0;
            den        <= '0;
            r          <= '0;
            lo         <= '0;
            q          <= '0;
            neg        <= 1'b0;
            ovf        <= 1'b0;
            similarity <= '0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == S_IDLE || state_nx != state)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh   <= vec_a;
                        b_sh   <= vec_b;
                        dot    <= '0;
                        na     <= '0;
                        nb     <= '0;
                        rem_a  <= '0;
                        rem_b  <= '0;
                        root_a <= '0;
                        root_b <= '0;
                    end
                end
                S_MAC: begin
                    dot  <= dot + ACCW'(p_ab);
                    na   <= na + NW'(p_aa);
                    nb   <= nb + NW'(p_bb);
                    a_sh <= a_sh >> 32;
                    b_sh <= b_sh >> 32;
                end
                S_SQRT: begin
                    {rem_a, root_a} <= sq_a_nx;
                    {rem_b, root_b} <= sq_b_nx;
                    na <= na << 2;
                    nb <= nb << 2;
                end
                S_MUL: begin
                    den <= NW'(root_a) * NW'(root_b);
                    r   <= RDW'(dmag >> FRAC);
                    lo  <= {dmag[FRAC-1:0], {FRAC{1'b0}}};
                    neg <= dot[ACCW-1];
                    ovf <= 1'b0;
                    q   <= '0;
                end
                S_DIV: begin
                    // A dividend whose upper part already reaches den needs
                    // more than QW quotient bits: flag it for saturation.
                    if (cnt == '0) ovf <= (r >= RDW'(den));
                    r  <= r_nx;
                    lo <= lo << 1;
                    q  <= q_nx[QW-2:0];
                    if (last) begin
                        similarity <= res;
                        valid      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cosine_sim_core.sv
// tb_cosine_sim_core
//   Self-checking bench for cosine_sim_core. A 128-bit arithmetic reference
//   model predicts each result. A single negedge process checks valid and
//   similarity on every cycle against the predicted schedule. Directed vectors
//   add literal expectations.
module tb_cosine_sim_core;
    localparam int W    = 5;
    localparam int ACCW = 64 + $clog2(W) + 1;
    localparam int SQ   = (ACCW - 1 + 1) / 2;
    localparam int LAT  = W + SQ + 35;
    localparam logic [31:0] ONE = 32'h0001_0000;
    localparam logic [31:0] M1  = 32'hFFFF_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [32*W-1:0] vec_a, vec_b;
    logic [31:0]     similarity;
    logic            valid;

    always #5 clk = ~clk;

    cosine_sim_core #(.W(W), .FRAC(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .vec_a(vec_a),
        .vec_b(vec_b),
        .similarity(similarity),
        .valid(valid)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int due_edge = 0;
    int valids   = 0;
    bit chk_en   = 1'b0;
    bit pending  = 1'b0;
    bit ev;
    logic [31:0] exp_next, cur_exp = '0, last_sim = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_near(input string name, input logic [31:0] act, input logic [31:0] exp);
        int d;
        d = int'(act) - int'(exp);
        n_checks++;
        if (d > 1 || d < -1) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h +/-1", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [127:0] isqrt(input logic [127:0] n);
        logic [127:0] r, t;
        r = '0;
        for (int i = 40; i >= 0; i--) begin
            t = r | (128'd1 << i);
            if (t * t <= n) r = t;
        end
        return r;
    endfunction

    function automatic logic [31:0] model(input logic [32*W-1:0] a, input logic [32*W-1:0] b);
        logic signed [127:0] dot, na, nb, x, y;
        logic [127:0] den, mag, qv;
        logic [31:0] ea, eb;
        dot = '0; na = '0; nb = '0;
        for (int i = 0; i < W; i++) begin
            ea = a[32*i +: 32];
            eb = b[32*i +: 32];
            x = {{96{ea[31]}}, ea};
            y = {{96{eb[31]}}, eb};
            dot += x * y;
            na  += x * x;
            nb  += y * y;
        end
        den = isqrt(na) * isqrt(nb);
        if (den == 0) return 32'h0;
        mag = (dot < 0) ? -dot : dot;
        qv  = (mag << 16) / den;
        if (qv > 128'h7FFF_FFFF) qv = 128'h7FFF_FFFF;
`ifdef COSINE_SIM_CLAMP_EN
        if (qv > 128'h1_0000) qv = 128'h1_0000;
`endif
        return (dot < 0) ? -qv[31:0] : qv[31:0];
    endfunction

    function automatic logic [32*W-1:0] pk(input logic [31:0] e0, e1, e2, e3, e4);
        return {e4, e3, e2, e1, e0};
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            ev = pending && (cyc + 1 == due_edge);
            check("valid", {31'b0, valid}, {31'b0, ev});
            if (ev) begin
                cur_exp  = exp_next;
                pending  = 1'b0;
                last_sim = similarity;
                valids++;
            end
            check("similarity", similarity, cur_exp);
        end
    end

    // ---------------- driver helpers (called at posedge + 1) ----------------
    task automatic issue(input logic [32*W-1:0] a, input logic [32*W-1:0] b);
        vec_a = a;
        vec_b = b;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        vec_a    = {W{$urandom}};
        vec_b    = {W{$urandom}};
        exp_next = model(a, b);
        due_edge = cyc + LAT - 1;
        pending  = 1'b1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (pending && n < LAT + 10) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (pending) begin
            n_fail++;
            $display("FAIL timeout: valid not seen after %0d cycles, required within %0d", n, LAT);
            pending = 1'b0;
        end
    endtask

    task automatic run(input logic [32*W-1:0] a, input logic [32*W-1:0] b);
        issue(a, b);
        wait_done();
    endtask

    function automatic logic [31:0] rnd_el(input int mode);
        case (mode)
            0:       return $urandom;
            1:       return $urandom_range(6) - 32'd3;
            2:       return $urandom_range(32'h000F_FFFF) - 32'h0008_0000;
            default: return ($urandom_range(3) == 0) ? 32'h0 : $urandom_range(32'h0003_FFFF);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int v0;
        rst   = 1'b1;
        start = 1'b0;
        vec_a = '0;
        vec_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset_similarity", similarity, 32'h0);
        check("reset_valid", {31'b0, valid}, 32'h0);

        run(pk(ONE, ONE, ONE, ONE, ONE), pk(ONE, ONE, ONE, ONE, ONE));
        check("identical", last_sim, ONE);
        run(pk(ONE, ONE, ONE, ONE, ONE), pk(M1, M1, M1, M1, M1));
        check("opposite", last_sim, M1);
        run(pk(ONE, 0, 0, 0, 0), pk(0, ONE, 0, 0, 0));
        check("orthogonal", last_sim, 32'h0);
        run(pk(0, 0, 0, 0, 0), pk(ONE, 2*ONE, 3*ONE, 4*ONE, 5*ONE));
        check("zero_vector", last_sim, 32'h0);
        run(pk(ONE, 2*ONE, 3*ONE, 0, 0), pk(2*ONE, 4*ONE, 6*ONE, 0, 0));
`ifdef COSINE_SIM_CLAMP_EN
        check("scaled", last_sim, ONE);
`else
        check_near("scaled", last_sim, ONE);
`endif
        // Floor of tiny square roots pushes the ratio above 1.0.
        run(pk(1, 1, 0, 0, 0), pk(1, 1, 0, 0, 0));
`ifdef COSINE_SIM_CLAMP_EN
        check("lsb_pos", last_sim, ONE);
`else
        check("lsb_pos", last_sim, 32'h0002_0000);
`endif
        run(pk(1, 1, 0, 0, 0), pk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0));
`ifdef COSINE_SIM_CLAMP_EN
        check("lsb_neg", last_sim, M1);
`else
        check("lsb_neg", last_sim, 32'hFFFE_0000);
`endif

        // start re-pulsed during MAC is ignored: exactly one valid pulse
        v0 = valids;
        issue(pk(ONE, 0, ONE, 0, ONE), pk(ONE, ONE, ONE, 0, 0));
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done();
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("one_pulse_mac", valids - v0, 32'd1);

        // start held only during the DONE cycle is ignored
        v0 = valids;
        issue(pk(3*ONE, ONE, 0, 0, 0), pk(ONE, 2*ONE, 0, 0, 0));
        while (cyc < due_edge - 1) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("one_pulse_done", valids - v0, 32'd1);

        // reset in the middle of DIV aborts with no pulse and clears the result
        v0 = valids;
        issue(pk(ONE, ONE, 0, 0, 0), pk(ONE, 0, 0, 0, 0));
        repeat (50) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        pending = 1'b0;
        cur_exp = '0;
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("rst_no_pulse", valids - v0, 32'd0);
        check("rst_similarity", similarity, 32'h0);
        run(pk(ONE, ONE, ONE, ONE, ONE), pk(ONE, ONE, ONE, ONE, ONE));
        check("after_rst", last_sim, ONE);

        // randomized vectors against the model
        for (int t = 0; t < 35; t++) begin
            int mode, k, ai;
            logic [32*W-1:0] a, b;
            mode = t % 5;
            k = int'($urandom_range(6)) - 3;
            if (k == 0) k = 2;
            for (int i = 0; i < W; i++) begin
                if (mode == 4) begin
                    ai = (int'($urandom_range(10)) - 5) * 65536;
                    a[32*i +: 32] = 32'(ai);
                    b[32*i +: 32] = 32'(ai * k);
                end else begin
                    a[32*i +: 32] = rnd_el(mode);
                    b[32*i +: 32] = rnd_el(mode);
                end
            end
            run(a, b);
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule
